// File: rtl/ram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_portb_arbiter
// Purpose  : Shares port B of the data-memory BRAM between two requesters,
//            m0 (debug / program loader) and m1 (peripheral DMA). Requests
//            are serialised one at a time with round-robin fairness. The
//            arbiter drives web/addrb/dinb and returns read data after the
//            BRAM read latency. Port A is not touched by this block.
// Ports    : clk, rst_n (async, active low)
//            m0_* / m1_* : req, we[3:0] (0 = read), addr, wdata in;
//                          gnt (1-cycle pulse), rvalid (1-cycle pulse),
//                          rdata (held until next read of that requester) out
//            web, addrb, dinb : BRAM port B controls/data out
//            doutb            : BRAM port B read data in
//            busy             : high whenever the FSM is not IDLE
// Options  : `define PORTB_BURST_LOCK_EN lets the last owner keep the port
//            for up to MAX_BURST consecutive grants while the other side
//            waits. Default build: strict alternation on every tie.
// Revision : 1.0 - initial release
// ============================================================================
module ram_portb_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int READ_LAT  = 1,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic [3:0]    m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [3:0]    m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [3:0]    web,
   output logic [AW-1:0] addrb,
   output logic [DW-1:0] dinb,
   input  logic [DW-1:0] doutb,
   output logic          busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   // Value of lat_cnt in the WAIT cycle where doutb carries the read data.
   localparam logic [1:0] LAT_LAST = 2'(READ_LAT);

   generate
      if (READ_LAT < 1 || READ_LAT > 3 || MAX_BURST < 1) begin : g_bad_params
         $error("ram_portb_arbiter: READ_LAT must be 1..3 and MAX_BURST >= 1");
      end
   endgenerate

   logic [1:0]    state;
   logic          owner;       // 0 = m0, 1 = m1; owner of the transaction in flight
   logic          last_owner;  // owner of the most recently granted transaction
   logic [3:0]    we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [1:0]    lat_cnt;

   logic          any_req;
   logic          tie_pick;
   logic          sel;

`ifdef PORTB_BURST_LOCK_EN
   localparam int               BCW        = $clog2(MAX_BURST + 1);
   localparam logic [BCW-1:0]   BURST_MAX  = BCW'(MAX_BURST);
   localparam logic [BCW-1:0]   BURST_ONE  = BCW'(1);
   logic [BCW-1:0] burst_cnt;   // consecutive grants to last_owner; 0 = no burst running
`endif

   // ------------------------------------------------------------------------
   // Requester selection (only acted on in IDLE)
   // ------------------------------------------------------------------------
   always_comb begin
      any_req  = m0_req | m1_req;
      tie_pick = ~last_owner;
`ifdef PORTB_BURST_LOCK_EN
      // Last owner keeps the port while its burst budget lasts.
      if ((burst_cnt != '0) && (burst_cnt < BURST_MAX)) begin
         tie_pick = last_owner;
      end
`endif
      if (m0_req && m1_req) begin
         sel = tie_pick;
      end else begin
         sel = m1_req;
      end
   end

   // ------------------------------------------------------------------------
   // Main FSM and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;   // so m0 wins the first tie
         we_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_cnt    <= '0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  owner   <= sel;
                  we_q    <= sel ? m1_we    : m0_we;
                  addr_q  <= sel ? m1_addr  : m0_addr;
                  wdata_q <= sel ? m1_wdata : m0_wdata;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               last_owner <= owner;
               if (we_q != 4'b0000) begin
                  state <= S_IDLE;
               end else begin
                  lat_cnt <= 2'd1;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  if (owner) begin
                     m1_rdata <= doutb;
                  end else begin
                     m0_rdata <= doutb;
                  end
                  state <= S_RESP;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef PORTB_BURST_LOCK_EN
   // ------------------------------------------------------------------------
   // Burst counter: counts consecutive grants to the same owner, saturating
   // at MAX_BURST; cleared whenever IDLE finds nobody requesting.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt <= '0;
      end else if (state == S_IDLE) begin
         if (!any_req) begin
            burst_cnt <= '0;
         end else if ((sel == last_owner) && (burst_cnt != '0)) begin
            if (burst_cnt != BURST_MAX) begin
               burst_cnt <= burst_cnt + BURST_ONE;
            end
         end else begin
            burst_cnt <= BURST_ONE;
         end
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Outputs: all decoded from registers. In IDLE the BRAM side is quiet;
   // web is only ever non-zero during ISSUE.
   // ------------------------------------------------------------------------
   always_comb begin
      busy      = (state != S_IDLE);
      web       = (state == S_ISSUE) ? we_q : 4'b0000;
      addrb     = (state == S_IDLE) ? '0 : addr_q;
      dinb      = (state == S_IDLE) ? '0 : wdata_q;
      m0_gnt    = (state == S_ISSUE) && !owner;
      m1_gnt    = (state == S_ISSUE) &&  owner;
      m0_rvalid = (state == S_RESP)  && !owner;
      m1_rvalid = (state == S_RESP)  &&  owner;
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_portb_arbiter
// Purpose  : Self-checking bench for ram_portb_arbiter. Instance "a" uses
//            READ_LAT=1, instance "b" uses READ_LAT=3 (m1 tied off). Each
//            instance drives a small behavioural BRAM. Expected read
//            responses go into a scoreboard queue when a read is issued and
//            are popped when rvalid appears. Build with PORTB_BURST_LOCK_EN
//            defined to get the burst-lock grant order expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_portb_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- instance a (READ_LAT = 1) ----------------
   logic          m0_req = 0, m1_req = 0;
   logic [3:0]    m0_we = 0, m1_we = 0;
   logic [AW-1:0] m0_addr = 0, m1_addr = 0;
   logic [DW-1:0] m0_wdata = 0, m1_wdata = 0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [3:0]    web;
   logic [AW-1:0] addrb;
   logic [DW-1:0] dinb, doutb;
   logic          busy;

   ram_portb_arbiter #(.AW(AW), .DW(DW), .READ_LAT(1), .MAX_BURST(4)) u_a (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .busy(busy)
   );

   logic [31:0] mem_a [0:255];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (web[i]) mem_a[addrb[7:0]][8*i +: 8] <= dinb[8*i +: 8];
      doutb <= mem_a[addrb[7:0]];
   end

   // ---------------- instance b (READ_LAT = 3) ----------------
   logic          b_req = 0;
   logic [3:0]    b_we = 0;
   logic [AW-1:0] b_addr = 0;
   logic [DW-1:0] b_wdata = 0;
   logic          b_gnt, b_rvalid, b_m1_gnt, b_m1_rvalid;
   logic [DW-1:0] b_rdata, b_m1_rdata;
   logic [3:0]    b_web;
   logic [AW-1:0] b_addrb;
   logic [DW-1:0] b_dinb, b_doutb;
   logic          b_busy;

   ram_portb_arbiter #(.AW(AW), .DW(DW), .READ_LAT(3), .MAX_BURST(4)) u_b (
      .clk(clk), .rst_n(rst_n),
      .m0_req(b_req), .m0_we(b_we), .m0_addr(b_addr), .m0_wdata(b_wdata),
      .m0_gnt(b_gnt), .m0_rvalid(b_rvalid), .m0_rdata(b_rdata),
      .m1_req(1'b0), .m1_we(4'b0000), .m1_addr('0), .m1_wdata('0),
      .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
      .web(b_web), .addrb(b_addrb), .dinb(b_dinb), .doutb(b_doutb), .busy(b_busy)
   );

   logic [31:0] mem_b [0:255];
   logic [31:0] b_p1, b_p2;
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (b_web[i]) mem_b[b_addrb[7:0]][8*i +: 8] <= b_dinb[8*i +: 8];
      b_p1    <= mem_b[b_addrb[7:0]];
      b_p2    <= b_p1;
      b_doutb <= b_p2;
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          who;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   // Scoreboard consumer for instance a.
   always @(posedge clk) begin
      #1;
      if (m0_rvalid || m1_rvalid) begin
         if (sb.size() == 0) begin
            check("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rvalid_owner", {m1_rvalid, m0_rvalid}, e.who ? 2'b10 : 2'b01);
            check("rdata", e.who ? m1_rdata : m0_rdata, e.data);
         end
      end
   end

   // One transaction on instance a; reads push their expected data.
   task automatic xact(input bit who, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd);
      int n;
      if (we == 4'b0000) sb.push_back('{who, exp_rd});
      if (who) begin m1_we = we; m1_addr = addr; m1_wdata = data; m1_req = 1; end
      else     begin m0_we = we; m0_addr = addr; m0_wdata = data; m0_req = 1; end
      n = 0;
      do begin tick(); n++; end while (!(who ? m1_gnt : m0_gnt) && n < 10);
      check("xact_gnt", who ? m1_gnt : m0_gnt, 1'b1);
      m0_req = 0; m1_req = 0;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 10) begin tick(); n++; end
      check("xact_done", (sb.size() == 0) && !busy, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int c0, c1, n0, n1, n;
      logic [11:0] exp_order;
      logic [11:0] got_order;
      int ng;

      // Reset state
      tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_web", web, 4'h0);
      check("rst_addrb", addrb, 32'h0);
      check("rst_gnt_rvalid", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 4'h0);
      check("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
      rst_n = 1;
      tick();

      // m0 full write then read, exact cycle timing
      m0_we = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_req = 1;
      check("wr_c0_gnt", m0_gnt, 1'b0);
      tick();
      check("wr_c1_gnt", {m0_gnt, m1_gnt}, 2'b10);
      check("wr_c1_web", web, 4'hF);
      check("wr_c1_addr_din", {addrb, dinb}, {32'h10, 32'hDEADBEEF});
      m0_req = 0;
      tick();
      check("wr_c2_idle", {busy, web, m0_gnt}, 6'b0);
      sb.push_back('{1'b0, 32'hDEADBEEF});
      m0_we = 4'h0; m0_req = 1;
      tick();
      check("rd_c1_gnt_web", {m0_gnt, web}, 5'b1_0000);
      m0_req = 0;
      tick();
      check("rd_c2_wait", {busy, m0_rvalid, web}, 6'b1_0_0000);
      tick();
      check("rd_c3_rvalid", m0_rvalid, 1'b1);
      tick();
      check("rd_sb_empty", sb.size(), 0);

      // m1 seeds a word, then reset so both-request starts from reset
      xact(1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 32'h0);
      rst_n = 0; tick(); rst_n = 1; tick();

      // Simultaneous reads from reset: m0 first, m1 after m0 completes
      sb.push_back('{1'b0, 32'hDEADBEEF});
      sb.push_back('{1'b1, 32'hCAFEF00D});
      m0_we = 0; m0_addr = 32'h10; m0_req = 1;
      m1_we = 0; m1_addr = 32'h40; m1_req = 1;
      c0 = -1; c1 = -1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (m0_gnt) begin c0 = c; m0_req = 0; end
         if (m1_gnt) begin c1 = c; m1_req = 0; end
      end
      check("tie_m0_gnt_cycle", c0, 1);
      check("tie_m1_gnt_cycle", c1, 5);
      check("tie_sb_empty", sb.size(), 0);

      // Continuous writes, 6 per requester; record grant order
      tick(); tick();
`ifdef PORTB_BURST_LOCK_EN
      exp_order = 12'b1100_1111_0000;
`else
      exp_order = 12'b1010_1010_1010;
`endif
      got_order = '0; ng = 0; n0 = 0; n1 = 0;
      m0_we = 4'hF; m0_addr = 32'h80; m0_wdata = 32'hB000_0000; m0_req = 1;
      m1_we = 4'hF; m1_addr = 32'hA0; m1_wdata = 32'hA000_0000; m1_req = 1;
      n = 0;
      while (ng < 12 && n < 60) begin
         tick(); n++;
         if (m0_gnt) begin
            got_order[ng] = 1'b0; ng++; n0++;
            if (n0 == 6) m0_req = 0;
            else begin m0_addr = 32'h80 + n0; m0_wdata = 32'hB000_0000 | n0; end
         end
         if (m1_gnt) begin
            got_order[ng] = 1'b1; ng++; n1++;
            if (n1 == 6) m1_req = 0;
            else begin m1_addr = 32'hA0 + n1; m1_wdata = 32'hA000_0000 | n1; end
         end
      end
      m0_req = 0; m1_req = 0;
      check("burst_grant_count", ng, 12);
      for (int i = 0; i < 12; i++) check("grant_order", got_order[i], exp_order[i]);
      tick();
      xact(1'b1, 4'h0, 32'hA5, 32'h0, 32'hA000_0005);
      xact(1'b0, 4'h0, 32'h83, 32'h0, 32'hB000_0003);

      // Byte-lane write merge
      xact(1'b0, 4'hF, 32'h20, 32'h11223344, 32'h0);
      xact(1'b0, 4'b0100, 32'h20, 32'h00AB0000, 32'h0);
      xact(1'b0, 4'h0, 32'h20, 32'h0, 32'h11AB3344);

      // READ_LAT=3 instance: write, then read with exact timing
      b_we = 4'hF; b_addr = 32'h5; b_wdata = 32'h0BADF00D; b_req = 1;
      tick();
      check("b_wr_gnt", b_gnt, 1'b1);
      b_req = 0;
      tick();
      b_we = 4'h0; b_req = 1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin check("b_rd_gnt", b_gnt, 1'b1); b_req = 0; end
         check("b_busy", b_busy, (k <= 5));
         check("b_rvalid", b_rvalid, (k == 5));
         if (k == 5) check("b_rdata", b_rdata, 32'h0BADF00D);
      end

      // Reset asserted while a read sits in WAIT
      m0_we = 0; m0_addr = 32'h10; m0_req = 1;
      tick();
      check("rstw_gnt", m0_gnt, 1'b1);
      m0_req = 0;
      tick();
      check("rstw_in_wait", busy, 1'b1);
      rst_n = 0;
      #1;
      check("rstw_outputs", {busy, web, addrb, m0_gnt, m0_rvalid}, '0);
      check("rstw_rdata", {m0_rdata, m1_rdata}, 64'h0);
      tick();
      rst_n = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("rstw_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      end
      xact(1'b1, 4'h0, 32'h40, 32'h0, 32'hCAFEF00D);

      tick();
      check("final_sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_portb_arbiter.md
Name: ram_portb_arbiter

Overview:
- Shares port B of the data-memory block RAM between two requesters: m0 (debug/program loader) and m1 (peripheral DMA).
- Port A stays owned by the load/store unit and is not touched by this block.
- Serialises requests one at a time with round-robin fairness, drives web/addrb/dinb, and returns read data after the BRAM read latency.

Parameters:
- AW, 32, width of word address on requester and BRAM side
- DW, 32, data width
- READ_LAT, 1, BRAM doutb latency in clocks after the sampling edge; legal values 1..3
- MAX_BURST, 4, max consecutive grants to one requester (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  m0 request; held with m0_we/m0_addr/m0_wdata stable until m0_gnt
- m0_we  in  4  m0 byte write enables; 4'b0000 = read
- m0_addr  in  AW  m0 word address
- m0_wdata  in  DW  m0 write data
- m0_gnt  out  1  one-cycle pulse: request accepted and issued
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  DW  m0 read data, held until the next m0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, for m1
- web  out  4  BRAM port B byte write enables
- addrb  out  AW  BRAM port B word address
- dinb  out  DW  BRAM port B write data
- doutb  in  DW  BRAM port B read data
- busy  out  1  high in every state except IDLE

Behaviour:
- **Reset:** one clock domain; rst_n asynchronous, active low.
  - Clears FSM to IDLE, all gnt/rvalid to 0, rdata to 0, web/addrb/dinb to 0, last_owner to 1 (so m0 wins the first tie), and burst_cnt to 0.
  - Asserting reset mid-read discards the pending response; no rvalid is ever produced for it.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Only one requesting: select it.
  - Both requesting: select the one that is not last_owner.
  - Selected: register owner, we, addr, wdata into web/addrb/dinb; go to ISSUE.
  - No request: outputs zero, stay.
- **ISSUE (1 cycle):**
  - web/addrb/dinb hold the registered values; owner's gnt = 1; last_owner <= owner.
  - Write (we != 0): next state IDLE.
  - Read: next state WAIT with lat_cnt = 1.
- **WAIT:**
  - web = 0 and addrb held.
  - Stays READ_LAT cycles. In the cycle lat_cnt == READ_LAT, capture doutb into the owner's rdata and go to RESP.
- **RESP (1 cycle):** owner's rvalid = 1; next state IDLE.
- **Outside ISSUE:** web is always 0.
- **Read timing:** with request seen in IDLE at cycle 0:
  - gnt in cycle 1;
  - BRAM samples at the end of cycle 1;
  - rvalid in cycle READ_LAT+2.
- **Throughput:**
  - Write: 2 cycles per transaction.
  - Read: READ_LAT+3 cycles per transaction.
- **Other rules:**
  - A requester deasserting req before gnt is legal; the request is simply dropped.
  - The non-owner's req is ignored until IDLE.
  - Addresses are word addresses; byte alignment is the requester's responsibility, and no misalignment checking is done.
  - The other requester's gnt/rvalid/rdata are unaffected by a transaction.

Optional Feature:
- Macro: PORTB_BURST_LOCK_EN
- **Defined:**
  - In IDLE, if last_owner requests and burst_cnt < MAX_BURST, it is granted even if the other requester is waiting.
  - burst_cnt increments on each consecutive grant to the same owner.
  - burst_cnt resets to 1 on an owner switch and to 0 when IDLE sees no request.
  - On reaching MAX_BURST, the other requester (if requesting) wins next.
- **Undefined:** strict alternation on every tie; burst_cnt logic is absent.

Test Plan:
- m0 write we=4'b1111 addr=0x10 data=0xDEADBEEF, then m0 read addr=0x10 (READ_LAT=1) -> m0_gnt pulses in cycle 1, web=1111 only in the ISSUE cycle; read returns m0_rvalid in cycle 3 after its request, m0_rdata=0xDEADBEEF.
- m0 and m1 both request reads from reset -> m0 is granted first, then m1; each rvalid goes only to its owner with that owner's data; m1 sees no gnt while m0 is busy.
- Both requesters continuously issue 6 writes each, macro undefined -> grants alternate m0,m1,m0,...; macro defined with MAX_BURST=4 -> m0 x4, m1 x4, m0 x2, m1 x2.
- Byte write we=4'b0100 data=0x00AB0000 to a word holding 0x11223344, then read -> 0x11AB3344.
- READ_LAT=3: read issued -> rvalid exactly 5 cycles after the request; busy high for cycles 1–5.
- rst_n pulled low during WAIT -> all outputs 0 immediately; after release, no rvalid appears; a new m1 request completes normally.
